memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 32x16 data/instruction memory.
- Requester 0 is instruction fetch and requester 1 is load/store.
- Clears memory once after reset, then serves one access at a time with round-robin fairness.
- Drives all memory control and address/data inputs and returns read data plus a one-cycle ack to the winning requester.

Parameters:
- WORD_SIZE, 16, data width (shared parameters.vh).
- MEM_ADDR_SIZE, 5, address width (shared parameters.vh).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 access request; held until ack0
- we0  input  1  requester 0 write (1) / read (0); stable while req0
- addr0  input  MEM_ADDR_SIZE  requester 0 address; stable while req0
- wdata0  input  WORD_SIZE  requester 0 write data; stable while req0
- ack0  output  1  one-cycle completion pulse to requester 0
- rdata0  output  WORD_SIZE  read data for requester 0; valid only while ack0
- req1, we1, addr1, wdata1, ack1, rdata1  same as above, requester 1
- mem_reset  output  1  synchronous active-high clear to memory
- mem_read_enable  output  1  memory read strobe
- mem_write_enable  output  1  memory write strobe
- mem_address  output  MEM_ADDR_SIZE  memory address
- mem_data_in  output  WORD_SIZE  memory write data
- mem_data_out  input  WORD_SIZE  registered memory read data
- busy  output  1  high in every state except IDLE

Behaviour:
- **Clocking:** one clock; reset is asynchronous and active-low.
- **Registered outputs:** all outputs registered except rdata0/rdata1, which are mem_data_out gated by ackN (0 otherwise).
- **Reset values (reset low):**
  - state=INIT, mem_reset=1, busy=1, last_grant=1 so requester 0 wins the first tie.
  - All other outputs 0.
- **FSM states:** INIT, IDLE, ISSUE, RESP.
- **INIT:**
  - One cycle after reset release with mem_reset=1, which clears memory on that edge.
  - Next state IDLE; mem_reset=0.
  - Requests are ignored here.
- **IDLE:**
  - If neither req, stay.
  - If only one req, grant it.
  - If both, grant the one not equal to last_grant.
  - On grant: register mem_address=addrN, mem_data_in=wdataN, mem_write_enable=weN, mem_read_enable=~weN; set last_grant=N; go ISSUE.
- **ISSUE:**
  - Memory controls held for this cycle; memory samples them on the closing edge.
  - On that edge: clear read/write enables, assert ackN; go RESP.
- **RESP:**
  - ackN=1 for exactly one cycle; rdataN = mem_data_out (reads; for writes the value is don't-care).
  - Next state is always IDLE, and ack is cleared.
- **Requester rule:** requester drops req in the cycle after ack. The RESP→IDLE step guarantees a still-high req is not serviced twice.
- **Latency and throughput:**
  - req sampled high in IDLE at cycle 0 → ack in cycle 2; one access per 3 cycles.
  - Under continuous dual requests, grants alternate 0,1,0,1.
- **Stable-inputs rule:** addr/we/wdata are sampled only at the IDLE grant edge; later changes do not affect the access in flight.
- **Mid-operation reset:**
  - State returns to INIT asynchronously and any in-flight access is abandoned with no ack.
  - Memory is cleared again.
- **Widths:** no arithmetic; address passes through unmodified, so all 32 locations are reachable with no wrap logic.

Decomposition:
- WORD_SIZE, MEM_ADDR_SIZE and MEM_SIZE stay in the shared parameters.vh.
- FSM state encodings (INIT=2'd0, IDLE=2'd1, ISSUE=2'd2, RESP=2'd3) are added there as localparams.
- No sub-module is needed; the round-robin pick is a small combinational block inside.
- The bench instantiates memory_arbiter together with the existing memory module.

Test Plan:
- **Reset and clear:** assert reset low mid-simulation, release → mem_reset=1 for exactly one cycle, then busy=0. A subsequent read of addr 5 returns 16'h0000.
- **Single write/read:** req1 with we1=1, addr1=5'd7, wdata1=16'hBEEF → ack1 two cycles later. Then req1 read of addr 7 → ack1 with rdata1=16'hBEEF; rdata0=0 throughout.
- **Tie after reset:** req0 and req1 raised in the same cycle → ack0 first. ack1 follows 3 cycles later; mem_address shows addr0 then addr1.
- **Round-robin fairness:** both requesters hold req continuously for 6 transactions → ack order 0,1,0,1,0,1 with no back-to-back ack to the same port.
- **Stable-inputs:** change addr0 from 3 to 9 during ISSUE → memory accesses location 3 only, and location 9 is unchanged.
- **Mid-operation reset:** pull reset low during ISSUE of a write to addr 2 with 16'h1234 → no ack, INIT re-entered, memory re-cleared. A read of addr 2 then returns 16'h0000.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared sizes, FSM state encodings and the round-robin pick for memory_arbiter.
// Requester 0 is instruction fetch, requester 1 is load/store.
package memory_arbiter_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int MEM_ADDR_SIZE = 5;
    localparam int MEM_SIZE      = 32;

    localparam logic [1:0] STATE_INIT  = 2'd0;
    localparam logic [1:0] STATE_IDLE  = 2'd1;
    localparam logic [1:0] STATE_ISSUE = 2'd2;
    localparam logic [1:0] STATE_RESP  = 2'd3;

    // Returns the winning port (0 or 1); on a tie the port that did not win last time is chosen.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port 32x16 memory.
// Clears memory once after reset, then runs one IDLE->ISSUE->RESP access at a time.
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [MEM_ADDR_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0]     wdata0,
    output logic                     ack0,
    output logic [WORD_SIZE-1:0]     rdata0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [MEM_ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0]     wdata1,
    output logic                     ack1,
    output logic [WORD_SIZE-1:0]     rdata1,
    output logic                     mem_reset,
    output logic                     mem_read_enable,
    output logic                     mem_write_enable,
    output logic [MEM_ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]     mem_data_in,
    input  logic [WORD_SIZE-1:0]     mem_data_out,
    output logic                     busy
);

    logic [1:0] state;
    logic       last_grant;
    logic       active_port;
    logic       any_req;
    logic       grant_sel;

    always_comb begin
        any_req   = req0 | req1;
        grant_sel = pick_winner(req0, req1, last_grant);
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= STATE_INIT;
            mem_reset        <= 1'b1;
            busy             <= 1'b1;
            last_grant       <= 1'b1;
            active_port      <= 1'b0;
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_data_in      <= '0;
        end else begin
            case (state)
                STATE_INIT: begin
                    state     <= STATE_IDLE;
                    mem_reset <= 1'b0;
                    busy      <= 1'b0;
                end
                STATE_IDLE: begin
                    if (any_req) begin
                        state       <= STATE_ISSUE;
                        busy        <= 1'b1;
                        last_grant  <= grant_sel;
                        active_port <= grant_sel;
                        if (grant_sel) begin
                            mem_address      <= addr1;
                            mem_data_in      <= wdata1;
                            mem_write_enable <= we1;
                            mem_read_enable  <= ~we1;
                        end else begin
                            mem_address      <= addr0;
                            mem_data_in      <= wdata0;
                            mem_write_enable <= we0;
                            mem_read_enable  <= ~we0;
                        end
                    end
                end
                STATE_ISSUE: begin
                    state            <= STATE_RESP;
                    mem_read_enable  <= 1'b0;
                    mem_write_enable <= 1'b0;
                    ack0             <= ~active_port;
                    ack1             <= active_port;
                end
                STATE_RESP: begin
                    // Always pass through IDLE so a req still high during ack is not served twice.
                    state <= STATE_IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= STATE_INIT;
                    mem_reset <= 1'b1;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

    assign rdata0 = ack0 ? mem_data_out : '0;
    assign rdata1 = ack1 ? mem_data_out : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a behavioural memory and a transaction-level reference model.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    typedef struct {
        logic                     we;
        logic [MEM_ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0]     data;
        int                       gap;
        logic                     alt;
        logic [MEM_ADDR_SIZE-1:0] alt_addr;
    } txn_t;

    typedef struct {
        int                   port;
        logic [WORD_SIZE-1:0] data;
        int                   cyc;
    } ack_t;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     req0, we0, req1, we1;
    logic [MEM_ADDR_SIZE-1:0] addr0, addr1;
    logic [WORD_SIZE-1:0]     wdata0, wdata1;
    logic                     ack0, ack1;
    logic [WORD_SIZE-1:0]     rdata0, rdata1;
    logic                     mem_reset, mem_read_enable, mem_write_enable, busy;
    logic [MEM_ADDR_SIZE-1:0] mem_address;
    logic [WORD_SIZE-1:0]     mem_data_in;
    logic [WORD_SIZE-1:0]     mem_data_out = '0;
    logic [WORD_SIZE-1:0]     mem_array [MEM_SIZE];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done0 = 0, done1 = 0;
    int tgt0 = 0, tgt1 = 0;
    txn_t q0[$];
    txn_t q1[$];
    ack_t ack_log[$];
    logic [MEM_ADDR_SIZE-1:0] addr_log[$];

    always #5 clock = ~clock;

    memory_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_reset(mem_reset), .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .busy(busy)
    );

    // Single-port memory: synchronous clear, registered read data.
    always @(posedge clock) begin
        if (mem_reset) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_array[i] <= '0;
        end else begin
            if (mem_write_enable) mem_array[mem_address] <= mem_data_in;
            if (mem_read_enable) mem_data_out <= mem_array[mem_address];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [MEM_ADDR_SIZE-1:0] a,
                                input logic [WORD_SIZE-1:0] d, input int gap,
                                input logic alt, input logic [MEM_ADDR_SIZE-1:0] aa);
        txn_t t;
        t.we = we; t.addr = a; t.data = d; t.gap = gap; t.alt = alt; t.alt_addr = aa;
        return t;
    endfunction

    // Reference model: an access occupies the arbiter for three cycles after its grant edge
    // (controls visible for 1 cycle, then the ack cycle, then a free cycle); ties go to the
    // port that did not win last time.
    logic [WORD_SIZE-1:0]     ref_mem [MEM_SIZE];
    logic                     m_init = 1'b1;
    int                       m_left = 0;
    int                       m_port = 0;
    int                       m_last = 1;
    logic                     m_we = 1'b0;
    logic [MEM_ADDR_SIZE-1:0] m_addr = '0;
    logic [WORD_SIZE-1:0]     m_wdata = '0;
    logic [WORD_SIZE-1:0]     m_rdata = '0;

    always @(negedge clock) begin
        logic e_ack0, e_ack1, e_issue;
        cyc++;
        if (!reset) begin
            m_init = 1'b1;
            m_left = 0;
            m_last = 1;
        end
        e_issue = (m_left == 2);
        e_ack0  = (m_left == 1) && (m_port == 0);
        e_ack1  = (m_left == 1) && (m_port == 1);
        checkOutput("mem_reset", mem_reset, m_init);
        checkOutput("busy", busy, m_init || m_left > 0);
        checkOutput("ack0", ack0, e_ack0);
        checkOutput("ack1", ack1, e_ack1);
        checkOutput("mem_read_enable", mem_read_enable, e_issue && !m_we);
        checkOutput("mem_write_enable", mem_write_enable, e_issue && m_we);
        if (e_issue) checkOutput("mem_address", mem_address, m_addr);
        if (e_issue && m_we) checkOutput("mem_data_in", mem_data_in, m_wdata);
        if (!reset) checkOutput("mem_address_reset", mem_address, 0);
        if (!e_ack0) checkOutput("rdata0_idle", rdata0, 0);
        else if (!m_we) checkOutput("rdata0", rdata0, m_rdata);
        if (!e_ack1) checkOutput("rdata1_idle", rdata1, 0);
        else if (!m_we) checkOutput("rdata1", rdata1, m_rdata);

        if (ack0) ack_log.push_back('{0, rdata0, cyc});
        if (ack1) ack_log.push_back('{1, rdata1, cyc});
        if (mem_read_enable || mem_write_enable) addr_log.push_back(mem_address);

        // Advance to the next cycle using the inputs the coming edge will sample.
        if (!reset || m_init) begin
            for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = '0;
            if (reset) m_init = 1'b0;
        end else if (m_left == 2) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else m_rdata = ref_mem[m_addr];
            m_left = 1;
        end else if (m_left == 1) begin
            m_left = 0;
        end else if (req0 || req1) begin
            if (req0 && req1) m_port = 1 - m_last;
            else m_port = req1 ? 1 : 0;
            m_we    = m_port == 1 ? we1 : we0;
            m_addr  = m_port == 1 ? addr1 : addr0;
            m_wdata = m_port == 1 ? wdata1 : wdata0;
            m_last  = m_port;
            m_left  = 2;
        end
    end

    // Requester 0: raise req, optionally change addr during ISSUE, drop req the cycle after ack.
    initial begin
        txn_t t;
        logic got, aborted;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        forever begin
            @(posedge clock);
            if (q0.size() > 0) begin
                t = q0.pop_front();
                repeat (t.gap) @(posedge clock);
                #2 we0 = t.we; addr0 = t.addr; wdata0 = t.data; req0 = 1;
                if (t.alt) begin
                    @(posedge clock);
                    #2 addr0 = t.alt_addr;
                end
                got = 0; aborted = 0;
                for (int k = 0; k < 60; k++) begin
                    @(negedge clock);
                    if (!reset) begin aborted = 1; break; end
                    if (ack0) begin got = 1; break; end
                end
                if (!got && !aborted) checkOutput("ack0_timeout", 0, 1);
                if (!aborted) begin @(posedge clock); #2; end
                req0 = 0;
                done0++;
            end
        end
    end

    // Requester 1: same protocol.
    initial begin
        txn_t t;
        logic got, aborted;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        forever begin
            @(posedge clock);
            if (q1.size() > 0) begin
                t = q1.pop_front();
                repeat (t.gap) @(posedge clock);
                #2 we1 = t.we; addr1 = t.addr; wdata1 = t.data; req1 = 1;
                if (t.alt) begin
                    @(posedge clock);
                    #2 addr1 = t.alt_addr;
                end
                got = 0; aborted = 0;
                for (int k = 0; k < 60; k++) begin
                    @(negedge clock);
                    if (!reset) begin aborted = 1; break; end
                    if (ack1) begin got = 1; break; end
                end
                if (!got && !aborted) checkOutput("ack1_timeout", 0, 1);
                if (!aborted) begin @(posedge clock); #2; end
                req1 = 0;
                done1++;
            end
        end
    end

    task automatic waitDone(input string name);
        logic ok;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done0 >= tgt0 && done1 >= tgt1) begin ok = 1; break; end
            @(posedge clock);
        end
        if (!ok) checkOutput(name, 0, 1);
    endtask

    // Called with reset already low: hold it, release, then expect exactly one clear cycle.
    task automatic applyStimulus(input string name);
        int cnt;
        repeat (2) @(posedge clock);
        #2 reset = 1;
        cnt = 0;
        repeat (3) begin
            @(negedge clock);
            if (mem_reset) cnt++;
        end
        checkOutput({name, "_clear_pulse"}, cnt, 1);
        checkOutput({name, "_busy_after_clear"}, busy, 0);
    endtask

    initial begin
        int base, abase;
        logic found;
        #1 reset = 0;
        applyStimulus("power_on");

        // Single write then read through requester 1.
        base = ack_log.size();
        q1.push_back(mk(1, 5'd7, 16'hBEEF, 0, 0, 5'd0));
        q1.push_back(mk(0, 5'd7, 16'h0000, 0, 0, 5'd0));
        tgt1 += 2;
        waitDone("single_timeout");
        checkOutput("single_ack_count", ack_log.size() - base, 2);
        checkOutput("single_read_port", ack_log[base+1].port, 1);
        checkOutput("single_read_data", ack_log[base+1].data, 16'hBEEF);

        // Tie immediately after reset: port 0 must win, port 1 three cycles later.
        #2 reset = 0;
        applyStimulus("tie_reset");
        base = ack_log.size();
        abase = addr_log.size();
        q0.push_back(mk(0, 5'd3, 16'h0, 0, 0, 5'd0));
        q1.push_back(mk(0, 5'd4, 16'h0, 0, 0, 5'd0));
        tgt0 += 1; tgt1 += 1;
        waitDone("tie_timeout");
        checkOutput("tie_first_port", ack_log[base].port, 0);
        checkOutput("tie_second_port", ack_log[base+1].port, 1);
        checkOutput("tie_ack_spacing", ack_log[base+1].cyc - ack_log[base].cyc, 3);
        checkOutput("tie_addr_first", addr_log[abase], 5'd3);
        checkOutput("tie_addr_second", addr_log[abase+1], 5'd4);

        // Continuous dual requests alternate 0,1,0,1,0,1.
        base = ack_log.size();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(0, 5'(i), 16'h0, 0, 0, 5'd0));
            q1.push_back(mk(1, 5'(i + 10), 16'(i + 16'h100), 0, 0, 5'd0));
        end
        tgt0 += 3; tgt1 += 3;
        waitDone("fair_timeout");
        for (int i = 0; i < 6; i++) checkOutput($sformatf("fair_order_%0d", i), ack_log[base+i].port, i % 2);

        // Address changed from 3 to 9 during ISSUE must not redirect the write.
        q1.push_back(mk(1, 5'd9, 16'h5555, 0, 0, 5'd0));
        tgt1 += 1;
        waitDone("stable_pre_timeout");
        q0.push_back(mk(1, 5'd3, 16'h7777, 0, 1, 5'd9));
        tgt0 += 1;
        waitDone("stable_wr_timeout");
        base = ack_log.size();
        q1.push_back(mk(0, 5'd3, 16'h0, 0, 0, 5'd0));
        q1.push_back(mk(0, 5'd9, 16'h0, 0, 0, 5'd0));
        tgt1 += 2;
        waitDone("stable_rd_timeout");
        checkOutput("stable_loc3", ack_log[base].data, 16'h7777);
        checkOutput("stable_loc9", ack_log[base+1].data, 16'h5555);

        // Reset during ISSUE of a write: no ack, memory cleared again.
        q1.push_back(mk(1, 5'd5, 16'hAAAA, 0, 0, 5'd0));
        tgt1 += 1;
        waitDone("midrst_pre_timeout");
        q0.push_back(mk(1, 5'd2, 16'h1234, 0, 0, 5'd0));
        tgt0 += 1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #3;
            if (mem_write_enable) begin found = 1; break; end
        end
        checkOutput("midrst_issue_seen", found, 1);
        base = ack_log.size();
        reset = 0;
        applyStimulus("midrst");
        waitDone("midrst_abort_timeout");
        checkOutput("midrst_no_ack", ack_log.size() - base, 0);
        q1.push_back(mk(0, 5'd2, 16'h0, 0, 0, 5'd0));
        q1.push_back(mk(0, 5'd5, 16'h0, 0, 0, 5'd0));
        tgt1 += 2;
        waitDone("midrst_rd_timeout");
        checkOutput("midrst_loc2", ack_log[base].data, 16'h0000);
        checkOutput("midrst_loc5", ack_log[base+1].data, 16'h0000);

        // Randomised traffic on both ports, checked cycle by cycle against the model.
        for (int i = 0; i < 30; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
                            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))));
            q1.push_back(mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
                            int'($urandom_range(0, 3)), 1'b0, 5'd0));
        end
        tgt0 += 30; tgt1 += 30;
        waitDone("random_timeout");

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
